// File: rtl/booth_mul_arbiter.sv
// Two-requester round-robin front end for one shared booth_multiplier32.
// Optional WAIT timeout, enabled by defining MUL_TIMEOUT_EN.
module booth_mul_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] r0,
  output logic [63:0] r1,
  output logic        err,
  output logic        busy,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_r,
  input  logic        mul_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, DONE} state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("booth_mul_arbiter: TIMEOUT must be at least 1");
  end

  state_t state;
  logic   prio;    // requester favoured on a tie
  logic   winner;  // requester owning the in-flight multiply
  logic   pick;

  // A lone requester always wins; a tie goes to the requester not served last.
  assign pick = (req0 && req1) ? prio : req1;

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // NOTE: every register here is written with <= so all of them update from
  // pre-edge values; a blocking write would leak a new state into this edge.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      winner    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      r0        <= '0;
      r1        <= '0;
`ifdef MUL_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      mul_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            winner    <= pick;
            prio      <= ~pick;
            mul_a     <= pick ? a1 : a0;
            mul_b     <= pick ? b1 : b0;
            gnt0      <= ~pick;
            gnt1      <= pick;
            mul_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= GUARD;
        GUARD: begin
          // mul_ready here may still belong to the previous product.
          state <= WAIT;
`ifdef MUL_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mul_ready) begin
            if (winner) r1 <= mul_r;
            else        r0 <= mul_r;
            done0 <= ~winner;
            done1 <= winner;
            state <= DONE;
          end
`ifdef MUL_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            if (winner) r1 <= '0;
            else        r0 <= '0;
            done0 <= ~winner;
            done1 <= winner;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
